// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Memory-side responder for the core's data memory request interface.
//   Services 32-bit word loads/stores against an internal word-addressed
//   array after a fixed number of wait states, stalling the pipeline while
//   the request is outstanding and pulsing ready (with optional error) for
//   exactly one cycle on completion.
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   mem_addr   in   [31:0] byte address of request
//   mem_wdata  in   [31:0] store data
//   mem_rd_en  in   load request, held until mem_ready
//   mem_wr_en  in   store request, held until mem_ready
//   mem_rdata  out  [31:0] load data, valid with mem_ready && !mem_err
//   mem_ready  out  one-cycle completion pulse
//   mem_err    out  access fault, qualified by mem_ready
//   mem_stall  out  combinational pipeline stall request
module data_mem_responder #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h2000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_rd_en,
    input  logic        mem_wr_en,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        mem_err,
    output logic        mem_stall
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    // Byte span of the array. 33 bits so ADDR_WIDTH=30 does not wrap to 0.
    localparam logic [32:0] SPAN = 33'd4 << ADDR_WIDTH;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

    logic [31:0] mem_q [0:DEPTH-1];

    logic                  req;
    logic [31:0]           cur_addr;
    logic [31:0]           off;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  fault;
    logic                  enter_resp;
    logic                  mem_we;

    assign req = mem_rd_en | mem_wr_en;

    // In IDLE the request is evaluated straight off the inputs (needed when
    // WAIT_STATES=0 sends us to RESP on the acceptance edge); afterwards only
    // the latched copy is used so requester changes have no effect.
    assign cur_addr = (state_q == S_IDLE) ? mem_addr : addr_q;
    assign off      = cur_addr - BASE_ADDR;
    assign idx      = off[ADDR_WIDTH+1:2];

    // Addresses below BASE_ADDR wrap to huge offsets and fail the span check.
    assign fault = (cur_addr[1:0] != 2'b00)
                || ({1'b0, off} >= SPAN)
                || (mem_rd_en && mem_wr_en);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    addr_d  = mem_addr;
                    wdata_d = mem_wdata;
                    rd_d    = mem_rd_en;
                    wr_d    = mem_wr_en;
                    err_d   = fault;
                    cnt_d   = WAIT_STATES[3:0];
                    state_d = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Read data is captured on the edge entering RESP so it is registered and
    // present for the whole RESP cycle; every other cycle it returns to zero.
    assign enter_resp = (state_d == S_RESP) && (state_q != S_RESP);

    always_comb begin
        rdata_d = 32'd0;
        if (enter_resp && rd_d && !err_d) rdata_d = mem_q[idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Store commits on the edge leaving RESP. Reset forces IDLE, so an
    // aborted store never reaches this point.
    assign mem_we = rst_n && (state_q == S_RESP) && wr_q && !err_q;

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[idx] <= wdata_q;
    end

    assign mem_ready = (state_q == S_RESP);
    assign mem_err   = (state_q == S_RESP) && err_q;
    assign mem_rdata = rdata_q;
    assign mem_stall = ((state_q == S_IDLE) && req) || (state_q == S_WAIT);

`ifndef SYNTHESIS
    a_ready_pulse: assert property (@(posedge clk) disable iff (!rst_n)
        mem_ready |=> !mem_ready);
    a_stall_ready: assert property (@(posedge clk) disable iff (!rst_n)
        !(mem_stall && mem_ready));
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [31:0] rdata [3];
    logic [2:0]  rd_en, wr_en, ready, err, stall;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Index 0: WAIT_STATES=1, index 1: WAIT_STATES=0, index 2: WAIT_STATES=4
    data_mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(1)) u_ws1 (
        .clk(clk), .rst_n(rst_n), .mem_addr(addr[0]), .mem_wdata(wdata[0]),
        .mem_rd_en(rd_en[0]), .mem_wr_en(wr_en[0]), .mem_rdata(rdata[0]),
        .mem_ready(ready[0]), .mem_err(err[0]), .mem_stall(stall[0]));
    data_mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst_n(rst_n), .mem_addr(addr[1]), .mem_wdata(wdata[1]),
        .mem_rd_en(rd_en[1]), .mem_wr_en(wr_en[1]), .mem_rdata(rdata[1]),
        .mem_ready(ready[1]), .mem_err(err[1]), .mem_stall(stall[1]));
    data_mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(4)) u_ws4 (
        .clk(clk), .rst_n(rst_n), .mem_addr(addr[2]), .mem_wdata(wdata[2]),
        .mem_rd_en(rd_en[2]), .mem_wr_en(wr_en[2]), .mem_rdata(rdata[2]),
        .mem_ready(ready[2]), .mem_err(err[2]), .mem_stall(stall[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // Present one request to DUT idx at the next cycle, hold it until ready,
    // then drop it. Reports data, error, issue/ready cycles and stall count.
    task automatic do_req(input int idx, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rdat, output logic er,
                          output int issue, output int rdy, output int stalls);
        logic done;
        @(negedge clk);
        addr[idx]  = a;
        wdata[idx] = d;
        rd_en[idx] = rd;
        wr_en[idx] = wr;
        issue  = cyc;
        rdy    = -1;
        stalls = 0;
        rdat   = 32'hxxxx_xxxx;
        er     = 1'bx;
        done   = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            if (stall[idx]) stalls++;
            if (ready[idx]) begin
                rdat = rdata[idx];
                er   = err[idx];
                rdy  = cyc;
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        rd_en[idx] = 1'b0;
        wr_en[idx] = 1'b0;
        if (!done) check("timeout", 32'(done), 32'd1);
    endtask

    logic [31:0] rd_v;
    logic        er_v;
    int          t_iss, t_rdy, n_st, t_iss2, t_rdy2;

    initial begin
        rst_n = 1'b0;
        rd_en = '0;
        wr_en = '0;
        for (int i = 0; i < 3; i++) begin
            addr[i]  = 32'd0;
            wdata[i] = 32'd0;
        end
        repeat (3) @(negedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_rdata%0d", i), rdata[i], 32'd0);
            check($sformatf("reset_ready%0d", i), {31'd0, ready[i]}, 32'd0);
            check($sformatf("reset_err%0d", i),   {31'd0, err[i]},   32'd0);
            check($sformatf("reset_stall%0d", i), {31'd0, stall[i]}, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // WAIT_STATES=1: write then read
        do_req(0, 1'b0, 1'b1, 32'h2000_0010, 32'hDEAD_BEEF, rd_v, er_v, t_iss, t_rdy, n_st);
        check("ws1_wr_lat",   32'(t_rdy - t_iss), 32'd2);
        check("ws1_wr_stall", 32'(n_st), 32'd2);
        check("ws1_wr_err",   {31'd0, er_v}, 32'd0);
        do_req(0, 1'b1, 1'b0, 32'h2000_0010, 32'h0, rd_v, er_v, t_iss, t_rdy, n_st);
        check("ws1_rd_lat",   32'(t_rdy - t_iss), 32'd2);
        check("ws1_rd_data",  rd_v, 32'hDEAD_BEEF);
        check("ws1_rd_err",   {31'd0, er_v}, 32'd0);

        // WAIT_STATES=0: seed two words, then back-to-back reads
        do_req(1, 1'b0, 1'b1, 32'h2000_0000, 32'h0BAD_F00D, rd_v, er_v, t_iss, t_rdy, n_st);
        check("ws0_wr_lat",   32'(t_rdy - t_iss), 32'd1);
        do_req(1, 1'b0, 1'b1, 32'h2000_0004, 32'h1357_9BDF, rd_v, er_v, t_iss, t_rdy, n_st);
        do_req(1, 1'b1, 1'b0, 32'h2000_0000, 32'h0, rd_v, er_v, t_iss, t_rdy, n_st);
        check("ws0_rd0_lat",   32'(t_rdy - t_iss), 32'd1);
        check("ws0_rd0_stall", 32'(n_st), 32'd1);
        check("ws0_rd0_data",  rd_v, 32'h0BAD_F00D);
        do_req(1, 1'b1, 1'b0, 32'h2000_0004, 32'h0, rd_v, er_v, t_iss2, t_rdy2, n_st);
        check("ws0_b2b_lat",   32'(t_rdy2 - t_iss), 32'd3);
        check("ws0_rd1_data",  rd_v, 32'h1357_9BDF);

        // Misaligned store faults and leaves memory alone
        do_req(0, 1'b0, 1'b1, 32'h2000_0000, 32'hCAFE_0001, rd_v, er_v, t_iss, t_rdy, n_st);
        do_req(0, 1'b0, 1'b1, 32'h2000_0002, 32'h1234_5678, rd_v, er_v, t_iss, t_rdy, n_st);
        check("misal_err", {31'd0, er_v}, 32'd1);
        check("misal_lat", 32'(t_rdy - t_iss), 32'd2);
        do_req(0, 1'b1, 1'b0, 32'h2000_0000, 32'h0, rd_v, er_v, t_iss, t_rdy, n_st);
        check("misal_keep", rd_v, 32'hCAFE_0001);

        // Range checks
        do_req(0, 1'b1, 1'b0, 32'h2000_1000, 32'h0, rd_v, er_v, t_iss, t_rdy, n_st);
        check("oor_hi_err",  {31'd0, er_v}, 32'd1);
        check("oor_hi_data", rd_v, 32'd0);
        do_req(0, 1'b1, 1'b0, 32'h1FFF_FFFC, 32'h0, rd_v, er_v, t_iss, t_rdy, n_st);
        check("oor_lo_err",  {31'd0, er_v}, 32'd1);
        check("oor_lo_data", rd_v, 32'd0);
        do_req(0, 1'b0, 1'b1, 32'h2000_0FFC, 32'h0F0F_0F0F, rd_v, er_v, t_iss, t_rdy, n_st);
        do_req(0, 1'b1, 1'b0, 32'h2000_0FFC, 32'h0, rd_v, er_v, t_iss, t_rdy, n_st);
        check("top_err",  {31'd0, er_v}, 32'd0);
        check("top_data", rd_v, 32'h0F0F_0F0F);

        // Simultaneous rd+wr faults, location untouched
        do_req(0, 1'b0, 1'b1, 32'h2000_0008, 32'h5555_AAAA, rd_v, er_v, t_iss, t_rdy, n_st);
        do_req(0, 1'b1, 1'b1, 32'h2000_0008, 32'hFFFF_FFFF, rd_v, er_v, t_iss, t_rdy, n_st);
        check("both_err",  {31'd0, er_v}, 32'd1);
        check("both_data", rd_v, 32'd0);
        do_req(0, 1'b1, 1'b0, 32'h2000_0008, 32'h0, rd_v, er_v, t_iss, t_rdy, n_st);
        check("both_keep", rd_v, 32'h5555_AAAA);

        // WAIT_STATES=4: reset during WAIT aborts the store
        do_req(2, 1'b0, 1'b1, 32'h2000_0020, 32'h1111_2222, rd_v, er_v, t_iss, t_rdy, n_st);
        check("ws4_lat", 32'(t_rdy - t_iss), 32'd5);
        @(negedge clk);
        addr[2]  = 32'h2000_0020;
        wdata[2] = 32'hA5A5_A5A5;
        wr_en[2] = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("ws4_wait_stall", {31'd0, stall[2]}, 32'd1);
        #1;
        rst_n    = 1'b0;
        wr_en[2] = 1'b0;
        #1;
        check("rst_ready", {31'd0, ready[2]}, 32'd0);
        check("rst_err",   {31'd0, err[2]},   32'd0);
        check("rst_rdata", rdata[2], 32'd0);
        check("rst_stall", {31'd0, stall[2]}, 32'd0);
        repeat (6) @(negedge clk);
        rst_n = 1'b1;
        do_req(2, 1'b1, 1'b0, 32'h2000_0020, 32'h0, rd_v, er_v, t_iss, t_rdy, n_st);
        check("rst_keep", rd_v, 32'h1111_2222);
        check("rst_keep_err", {31'd0, er_v}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
